// File: rtl/axis_pack_16to32.sv
// Packs pairs of 16-bit AXI-Stream samples into little-endian 32-bit words; tlast closes a word early.
// Optional PACKER_STATS_EN adds pkt_count / odd_count packet statistics.
module axis_pack_16to32 (
    input  logic        aclk,
    input  logic        rst,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
`ifdef PACKER_STATS_EN
   ,output logic [31:0] pkt_count,
    output logic [15:0] odd_count
`endif
);

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned KEEP_W   = 4;

    localparam logic [KEEP_W-1:0] KEEP_LO   = KEEP_W'(4'b0011);
    localparam logic [KEEP_W-1:0] KEEP_FULL = KEEP_W'(4'b1111);

    typedef enum logic {
        WAIT_LO = 1'b0,
        WAIT_HI = 1'b1
    } state_t;

    state_t              state;
    logic [SAMPLE_W-1:0] held_lo;
    logic                s_accept;
    logic                word_done;

    // Input is accepted whenever the output slot is empty or draining this cycle.
    assign s_axis_tready = !rst && (!m_axis_tvalid || m_axis_tready);
    assign s_accept      = s_axis_tvalid && s_axis_tready;
    assign word_done     = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_LO;
            held_lo       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (word_done) begin
                m_axis_tvalid <= 1'b0;
            end
            // A load in the same cycle as a drain overrides the clear above.
            if (s_accept) begin
                case (state)
                    WAIT_LO: begin
                        if (s_axis_tlast) begin
                            m_axis_tdata  <= {SAMPLE_W'(0), s_axis_tdata};
                            m_axis_tkeep  <= KEEP_LO;
                            m_axis_tlast  <= 1'b1;
                            m_axis_tvalid <= 1'b1;
                        end else begin
                            held_lo <= s_axis_tdata;
                            state   <= WAIT_HI;
                        end
                    end
                    WAIT_HI: begin
                        m_axis_tdata  <= {s_axis_tdata, held_lo};
                        m_axis_tkeep  <= KEEP_FULL;
                        m_axis_tlast  <= s_axis_tlast;
                        m_axis_tvalid <= 1'b1;
                        state         <= WAIT_LO;
                    end
                    default: begin
                        state <= WAIT_LO;
                    end
                endcase
            end
        end
    end

`ifdef PACKER_STATS_EN
    // Packet statistics count words as they leave, not as they are built.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
            odd_count <= '0;
        end else if (word_done && m_axis_tlast) begin
            pkt_count <= pkt_count + 32'd1;
            if (m_axis_tkeep == KEEP_LO) begin
                odd_count <= odd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_pack_16to32.sv
// Self-checking bench for axis_pack_16to32: packet-level reference model plus directed scenarios.
module tb_axis_pack_16to32;

    logic        aclk;
    logic        rst;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
`ifdef PACKER_STATS_EN
    logic [31:0] pkt_count;
    logic [15:0] odd_count;
`endif

    axis_pack_16to32 dut (
        .aclk          (aclk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef PACKER_STATS_EN
       ,.pkt_count     (pkt_count),
        .odd_count     (odd_count)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int words_seen = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected words as {tlast, tkeep, tdata}, built from accepted samples.
    logic [36:0] exp_q[$];
    logic [36:0] last_word;
    logic [36:0] prev_out;
    logic [36:0] got;
    logic [15:0] model_lo;
    bit          model_have_lo;
    bit          appear;
    bit          prev_stall;

    always @(negedge aclk) begin
        got = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (rst) begin
            exp_q.delete();
            model_have_lo = 0;
            appear        = 0;
            prev_stall    = 0;
        end else begin
            if (appear) begin
                chk("latency_valid", 64'(m_axis_tvalid), 64'(1));
                chk("latency_word", 64'(got), 64'(last_word));
            end
            appear = 0;
            chk("s_ready_rule", 64'(s_axis_tready), 64'(!m_axis_tvalid || m_axis_tready));
            if (prev_stall) chk("stall_hold", {27'(0), m_axis_tvalid, got}, {27'(0), 1'b1, prev_out});
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out   = got;
            if (m_axis_tvalid && m_axis_tready) begin
                words_seen++;
                if (exp_q.size() == 0) chk("spurious_word", 64'(got), 64'(0));
                else chk("word", 64'(got), 64'(exp_q.pop_front()));
            end
            if (s_axis_tvalid && s_axis_tready) begin
                if (model_have_lo) begin
                    last_word = {s_axis_tlast, 4'hF, s_axis_tdata, model_lo};
                    model_have_lo = 0;
                    exp_q.push_back(last_word);
                    appear = 1;
                end else if (s_axis_tlast) begin
                    last_word = {1'b1, 4'h3, 16'h0000, s_axis_tdata};
                    exp_q.push_back(last_word);
                    appear = 1;
                end else begin
                    model_lo = s_axis_tdata;
                    model_have_lo = 1;
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic l);
        int budget;
        budget = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        @(negedge aclk);
        while (!s_axis_tready && budget < 200) begin
            budget++;
            @(negedge aclk);
        end
        chk("send_accept", 64'(s_axis_tready), 64'(1));
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
        chk("rst_tkeep", 64'(m_axis_tkeep), 64'(0));
        chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
        chk("rst_s_ready", 64'(s_axis_tready), 64'(0));
`ifdef PACKER_STATS_EN
        chk("rst_pkt_count", 64'(pkt_count), 64'(0));
        chk("rst_odd_count", 64'(odd_count), 64'(0));
`endif
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        rst = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    logic [15:0] tbl_data[10] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505,
                                  16'h0606, 16'h0707, 16'h0808, 16'h0909, 16'h0A0A};
    logic        tbl_last[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0]  rdy_pat = 8'b1011_0010;

    initial begin
        int c0;
        int w0;
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        #1;
        chk("init_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("init_tdata", 64'(m_axis_tdata), 64'(0));
        chk("init_s_ready", 64'(s_axis_tready), 64'(0));
        @(posedge aclk);
        #1;
        rst = 1'b0;
        @(posedge aclk);
        #1;

        // Two samples, one full word
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        chk("pair_valid", 64'(m_axis_tvalid), 64'(1));
        chk("pair_word", {27'(0), m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {27'(0), 1'b1, 4'hF, 32'h2222_1111});
        idle(1);
        chk("drain_valid_drop", 64'(m_axis_tvalid), 64'(0));
        idle(1);

        // Odd-length packet
        do_reset();
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b0);
        chk("odd_w0", {27'(0), m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {27'(0), 1'b0, 4'hF, 32'hBBBB_AAAA});
        send(16'hCCCC, 1'b1);
        chk("odd_w1", {27'(0), m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {27'(0), 1'b1, 4'h3, 32'h0000_CCCC});
        idle(2);
`ifdef PACKER_STATS_EN
        chk("odd_pkt_count", 64'(pkt_count), 64'(1));
        chk("odd_odd_count", 64'(odd_count), 64'(1));
`endif

        // Back-to-back throughput
        c0 = cyc;
        w0 = words_seen;
        for (int i = 0; i < 8; i++) send(16'(16'h1000 + i), 1'(i == 7));
        chk("b2b_cycles", 64'(cyc - c0), 64'(8));
        idle(2);
        chk("b2b_words", 64'(words_seen - w0), 64'(4));

        // Downstream stall for 5 cycles, release with same-cycle accept
        m_axis_tready = 1'b0;
        send(16'h3333, 1'b0);
        send(16'h4444, 1'b1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'h5656;
        s_axis_tlast  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("stall_s_ready", 64'(s_axis_tready), 64'(0));
            chk("stall_word", {27'(0), m_axis_tvalid, m_axis_tkeep, m_axis_tdata}, {27'(0), 1'b1, 4'hF, 32'h4444_3333});
            @(posedge aclk);
            #1;
        end
        m_axis_tready = 1'b1;
        @(negedge aclk);
        chk("release_s_ready", 64'(s_axis_tready), 64'(1));
        @(posedge aclk);
        #1;
        chk("release_word", {27'(0), m_axis_tvalid, m_axis_tkeep, m_axis_tdata}, {27'(0), 1'b1, 4'h3, 32'h0000_5656});
        idle(2);

        // Reset while holding a low sample
        send(16'h5555, 1'b0);
        s_axis_tvalid = 1'b0;
        do_reset();
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b1);
        chk("post_rst_word", {27'(0), m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {27'(0), 1'b1, 4'hF, 32'h0002_0001});
        idle(2);

        // Mixed packets against a toggling downstream ready
        fork
            begin
                for (int i = 0; i < 10; i++) send(tbl_data[i], tbl_last[i]);
                s_axis_tvalid = 1'b0;
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    m_axis_tready = rdy_pat[k % 8];
                    @(posedge aclk);
                    #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        idle(3);
        chk("model_drained", 64'(exp_q.size()), 64'(0));

`ifdef PACKER_STATS_EN
        // Counter wrap with one-sample packets
        do_reset();
        for (int i = 0; i < 65537; i++) send(16'(i), 1'b1);
        idle(3);
        chk("wrap_pkt_count", 64'(pkt_count), 64'(65537));
        chk("wrap_odd_count", 64'(odd_count), 64'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_pack_16to32.md
AXIS_PACK_16TO32 -- requirements
Module: axis_pack_16to32

Interface
REQ-001 SHALL expose `aclk`, input, 1 bit: the single clock; all logic is rising-edge.
REQ-002 SHALL expose `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL expose `s_axis_tdata`, input, 16 bits: one sigmoid output sample.
REQ-004 SHALL expose `s_axis_tlast`, input, 1 bit: last sample of a packet.
REQ-005 SHALL expose `s_axis_tvalid`, input, 1 bit: input sample valid.
REQ-006 SHALL expose `s_axis_tready`, output, 1 bit: the block accepts a sample.
REQ-007 SHALL expose `m_axis_tdata`, output, 32 bits: packed word.
REQ-008 SHALL expose `m_axis_tkeep`, output, 4 bits: byte enables.
REQ-009 SHALL expose `m_axis_tlast`, output, 1 bit: last word of a packet.
REQ-010 SHALL expose `m_axis_tvalid`, output, 1 bit: output word valid.
REQ-011 SHALL expose `m_axis_tready`, input, 1 bit: downstream accepts the word.
REQ-012 SHALL expose `pkt_count`, output, 32 bits, only when PACKER_STATS_EN is defined: packets emitted.
REQ-013 SHALL expose `odd_count`, output, 16 bits, only when PACKER_STATS_EN is defined: packets emitted with an odd sample count.

Function
REQ-014 Handshake: a sample SHALL be accepted when `s_axis_tvalid` and `s_axis_tready` are both 1; a word SHALL complete when `m_axis_tvalid` and `m_axis_tready` are both 1.
REQ-015 `s_axis_tready` SHALL equal (`!m_axis_tvalid || m_axis_tready`) and SHALL be 0 while `rst` is asserted.
REQ-016 The FSM SHALL have two states:
- WAIT_LO: no sample is held.
- WAIT_HI: a low sample is held in a 16-bit register.
REQ-017 In WAIT_LO, an accepted sample with tlast=0 SHALL be stored and the FSM SHALL go to WAIT_HI; no output word is produced.
REQ-018 In WAIT_LO, an accepted sample with tlast=1 SHALL produce a word: tdata = {16'h0000, sample}, tkeep = 4'b0011, tlast = 1; the FSM stays in WAIT_LO.
REQ-019 In WAIT_HI, an accepted sample SHALL produce a word: tdata = {sample, held_lo}, tkeep = 4'b1111, tlast = the sample's tlast; the FSM returns to WAIT_LO.
REQ-020 The output word SHALL be registered and SHALL appear with `m_axis_tvalid` = 1 on the cycle after the completing sample is accepted (latency 1 cycle).
REQ-021 While `m_axis_tvalid` = 1 and `m_axis_tready` = 0, `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` SHALL hold stable and no sample SHALL be accepted.
REQ-022 On a word completion with no new word loaded in the same cycle, `m_axis_tvalid` SHALL drop to 0 on the next cycle.
REQ-023 Simultaneous drain and load in one cycle SHALL replace the output word with no bubble; sustained throughput SHALL be 1 sample per cycle (1 word per 2 cycles).
REQ-024 Word order SHALL be little-endian: the earlier sample occupies bits [15:0].
REQ-025 A packet's words SHALL never mix samples from two packets; tlast always closes the current word.
REQ-026 A packet of 1 sample SHALL emit exactly one word with tkeep = 4'b0011.

Reset
REQ-027 Asserting `rst` SHALL immediately set:
- FSM to WAIT_LO, held low sample cleared;
- `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tkeep` = 0, `m_axis_tlast` = 0;
- counters to 0.
REQ-028 Reset mid-packet or mid-stall SHALL discard held and pending data; the first accepted sample after deassertion SHALL start a new word in WAIT_LO.

Configuration
REQ-029 With PACKER_STATS_EN defined:
- `pkt_count` SHALL increment by 1 on each completed word with tlast = 1;
- `odd_count` SHALL also increment when that word has tkeep = 4'b0011;
- both counters SHALL wrap modulo 2^32 and 2^16 respectively.
REQ-030 Without PACKER_STATS_EN, both ports and their counters SHALL be absent, and datapath behaviour SHALL be identical.

Verification
REQ-031 Samples 0x1111, 0x2222 (tlast=1), `m_axis_tready` = 1 -> one word 0x22221111, tkeep = 4'hF, tlast = 1, valid one cycle after the second acceptance.
REQ-032 Samples 0xAAAA, 0xBBBB, 0xCCCC (tlast=1) -> words 0xBBBBAAAA (tkeep = F, tlast = 0), then 0x0000CCCC (tkeep = 3, tlast = 1); with stats enabled, `pkt_count` = 1 and `odd_count` = 1.
REQ-033 Back-to-back 8 samples with `m_axis_tready` held at 1 -> 4 words, `s_axis_tready` constantly 1, no idle cycle on the input.
REQ-034 Word pending with `m_axis_tready` = 0 for 5 cycles -> `s_axis_tready` = 0 and outputs stable for those cycles; on release, the word completes and the next sample is accepted in the same cycle.
REQ-035 Assert `rst` while in WAIT_HI holding 0x5555 -> outputs go to 0 immediately; after release, samples 0x0001, 0x0002 (tlast=1) -> word 0x00020001 with no trace of 0x5555.
REQ-036 Stats enabled, 65537 one-sample packets -> `odd_count` wraps to 1 and `pkt_count` = 65537.
